// File: rtl/fsm_modo_libre_param_pkg.sv
// rtl/fsm_modo_libre_param_pkg.sv - shared state encodings and helpers for the free-play note FSM
package fsm_modo_libre_param_pkg;

  // FSM state encodings, kept as plain 2-bit constants for legacy compatibility
  localparam logic [1:0] REPOSO  = 2'd0;
  localparam logic [1:0] ESPERA  = 2'd1;
  localparam logic [1:0] SONANDO = 2'd2;
  localparam logic [1:0] PAUSA   = 2'd3;

  // Keyboard code meaning "no key pressed"
  localparam int TECLA_NINGUNA = 0;

  function automatic int f_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter width able to hold the largest reload value (cycles-1) of note or gap
  function automatic int f_ancho_cnt(input int ciclos_nota, input int ciclos_pausa);
    int m;
    m = f_max(f_max(ciclos_nota, ciclos_pausa), 2);
    return $clog2(m);
  endfunction

endpackage

// File: rtl/fsm_modo_libre_param_if.sv
// rtl/fsm_modo_libre_param_if.sv - keyboard/tone-side bus of the free-play note FSM
interface fsm_modo_libre_param_if #(
  parameter int ANCHO_TECLA = 8,
  parameter int ANCHO_NOTA  = 3,
  parameter int ANCHO_NIVEL = 3
);

  logic                   inicio;
  logic                   detener;
  logic [ANCHO_TECLA-1:0] entrada;
  logic [ANCHO_NOTA-1:0]  notaSalida;
  logic                   contar;
  logic                   ocupado;
  logic                   desborde;
  logic [ANCHO_NIVEL-1:0] nivel;

  // Controller side: drives commands and key codes, observes the player
  modport master (
    output inicio,
    output detener,
    output entrada,
    input  notaSalida,
    input  contar,
    input  ocupado,
    input  desborde,
    input  nivel
  );

  // Player side: the FSM itself
  modport slave (
    input  inicio,
    input  detener,
    input  entrada,
    output notaSalida,
    output contar,
    output ocupado,
    output desborde,
    output nivel
  );

endinterface

// File: rtl/fsm_modo_libre_param_cola.sv
// rtl/fsm_modo_libre_param_cola.sv - synchronous note FIFO with push/pop/flush and occupancy
module cola_notas #(
  parameter int ANCHO = 3,
  parameter int PROF  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_push,
  input  logic                        i_pop,
  input  logic                        i_flush,
  input  logic [ANCHO-1:0]            i_dato,
  output logic [ANCHO-1:0]            o_dato,
  output logic                        o_lleno,
  output logic                        o_vacio,
  output logic [$clog2(PROF):0]       o_nivel
);

  localparam int ANCHO_PTR = $clog2(PROF);

  logic [ANCHO-1:0]     r_mem [PROF];
  logic [ANCHO_PTR-1:0] r_wr;
  logic [ANCHO_PTR-1:0] r_rd;
  logic [ANCHO_PTR:0]   r_nivel;

  logic w_push;
  logic w_pop;

  // A pop frees a slot on the same edge, so a full queue still takes a push then
  assign w_pop   = i_pop && !o_vacio;
  assign w_push  = i_push && (!o_lleno || w_pop);

  assign o_vacio = (r_nivel == '0);
  assign o_lleno = (r_nivel == (ANCHO_PTR+1)'(PROF));
  assign o_nivel = r_nivel;
  assign o_dato  = r_mem[r_rd];

  // Pointer and level bookkeeping; flush empties the queue in one edge
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_nivel <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + ANCHO_PTR'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + ANCHO_PTR'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_nivel <= r_nivel + (ANCHO_PTR+1)'(1);
        2'b01:   r_nivel <= r_nivel - (ANCHO_PTR+1)'(1);
        default: r_nivel <= r_nivel;
      endcase
    end
  end

  // Storage write; contents need no reset since the level gates every read
  always_ff @(posedge clk) begin
    if (w_push && !i_flush && !reset) begin
      r_mem[r_wr] <= i_dato;
    end
  end

endmodule

// File: rtl/fsm_modo_libre_param.sv
// rtl/fsm_modo_libre_param.sv - free-play note FSM: key mapping, note queue, timed playback
module fsm_modo_libre_param
  import fsm_modo_libre_param_pkg::*;
#(
  parameter int ANCHO_TECLA  = 8,
  parameter int TECLA_BASE   = 65,
  parameter int NUM_NOTAS    = 8,
  parameter int ANCHO_NOTA   = 3,
  parameter int CICLOS_NOTA  = 50000,
  parameter int CICLOS_PAUSA = 0,
  parameter int PROF_COLA    = 4
) (
  input logic                  clk,
  input logic                  reset,
  fsm_modo_libre_param_if.slave io_bus
);

  localparam int ANCHO_NIVEL = $clog2(PROF_COLA) + 1;
  localparam int ANCHO_CNT   = f_ancho_cnt(CICLOS_NOTA, CICLOS_PAUSA);

  localparam logic [ANCHO_TECLA-1:0] LP_TECLA_MIN = ANCHO_TECLA'(TECLA_BASE);
  localparam logic [ANCHO_TECLA-1:0] LP_TECLA_MAX = ANCHO_TECLA'(TECLA_BASE + NUM_NOTAS - 1);
  localparam logic [ANCHO_CNT-1:0]   LP_CNT_NOTA  = ANCHO_CNT'(CICLOS_NOTA - 1);
  localparam logic [ANCHO_CNT-1:0]   LP_CNT_PAUSA = ANCHO_CNT'((CICLOS_PAUSA > 0) ? CICLOS_PAUSA - 1 : 0);

  logic [1:0]             r_estado;
  logic [ANCHO_TECLA-1:0] r_tecla_prev;
  logic [ANCHO_NOTA-1:0]  r_nota;
  logic                   r_contar;
  logic                   r_desborde;
  logic [ANCHO_CNT-1:0]   r_cnt;

  logic                   w_flanco;
  logic                   w_en_rango;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_fin_cnt;
  logic [ANCHO_NOTA-1:0]  w_indice;
  logic [ANCHO_NOTA-1:0]  w_nota_cola;
  logic                   w_lleno;
  logic                   w_vacio;
  logic [ANCHO_NIVEL-1:0] w_nivel;

  // A key counts once per change of the held code; stop discards any push that edge
  assign w_flanco   = (io_bus.entrada != r_tecla_prev);
  assign w_en_rango = (io_bus.entrada >= LP_TECLA_MIN) && (io_bus.entrada <= LP_TECLA_MAX);
  assign w_indice   = ANCHO_NOTA'(io_bus.entrada - LP_TECLA_MIN);
  assign w_push     = (r_estado != REPOSO) && w_flanco && w_en_rango && !io_bus.detener;
  assign w_fin_cnt  = (r_cnt == '0);

  // Decide whether the next note is taken from the queue this edge
  always_comb begin
    w_pop = 1'b0;
    if (!io_bus.detener) begin
      case (r_estado)
        ESPERA:  w_pop = !w_vacio;
        SONANDO: w_pop = w_fin_cnt && (CICLOS_PAUSA == 0) && !w_vacio;
        PAUSA:   w_pop = w_fin_cnt && !w_vacio;
        default: w_pop = 1'b0;
      endcase
    end
  end

  cola_notas #(
    .ANCHO (ANCHO_NOTA),
    .PROF  (PROF_COLA)
  ) u_cola (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (io_bus.detener),
    .i_dato  (w_indice),
    .o_dato  (w_nota_cola),
    .o_lleno (w_lleno),
    .o_vacio (w_vacio),
    .o_nivel (w_nivel)
  );

  // Key history for edge detection and the one-cycle overflow pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tecla_prev <= ANCHO_TECLA'(TECLA_NINGUNA);
      r_desborde   <= 1'b0;
    end else begin
      r_tecla_prev <= io_bus.entrada;
      r_desborde   <= w_push && w_lleno && !w_pop;
    end
  end

  // Playback FSM: wait for a queued note, sound it, optional gap, chain the next one
  always_ff @(posedge clk) begin
    if (reset) begin
      r_estado <= REPOSO;
      r_nota   <= '0;
      r_contar <= 1'b0;
      r_cnt    <= '0;
    end else if (io_bus.detener) begin
      r_estado <= REPOSO;
      r_nota   <= '0;
      r_contar <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_estado)
        REPOSO: begin
          if (io_bus.inicio) begin
            r_estado <= ESPERA;
          end
        end
        ESPERA: begin
          if (w_pop) begin
            r_estado <= SONANDO;
            r_nota   <= w_nota_cola;
            r_contar <= 1'b1;
            r_cnt    <= LP_CNT_NOTA;
          end
        end
        SONANDO: begin
          if (!w_fin_cnt) begin
            r_cnt <= r_cnt - ANCHO_CNT'(1);
          end else if (CICLOS_PAUSA > 0) begin
            r_estado <= PAUSA;
            r_contar <= 1'b0;
            r_cnt    <= LP_CNT_PAUSA;
          end else if (w_pop) begin
            r_nota <= w_nota_cola;
            r_cnt  <= LP_CNT_NOTA;
          end else begin
            r_estado <= ESPERA;
            r_contar <= 1'b0;
          end
        end
        PAUSA: begin
          if (!w_fin_cnt) begin
            r_cnt <= r_cnt - ANCHO_CNT'(1);
          end else if (w_pop) begin
            r_estado <= SONANDO;
            r_nota   <= w_nota_cola;
            r_contar <= 1'b1;
            r_cnt    <= LP_CNT_NOTA;
          end else begin
            r_estado <= ESPERA;
          end
        end
        default: begin
          r_estado <= REPOSO;
        end
      endcase
    end
  end

  assign io_bus.notaSalida = r_nota;
  assign io_bus.contar     = r_contar;
  assign io_bus.ocupado    = (r_estado == SONANDO) || (r_estado == PAUSA);
  assign io_bus.desborde   = r_desborde;
  assign io_bus.nivel      = w_nivel;

endmodule

// File: tb/tb_fsm_modo_libre_param.sv
// tb/tb_fsm_modo_libre_param.sv - directed vector bench for the free-play note FSM
module tb_fsm_modo_libre_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0;
  logic rst2;

  fsm_modo_libre_param_if #(.ANCHO_TECLA(8), .ANCHO_NOTA(3), .ANCHO_NIVEL(3)) bus0 ();
  fsm_modo_libre_param_if #(.ANCHO_TECLA(8), .ANCHO_NOTA(3), .ANCHO_NIVEL(3)) bus2 ();

  fsm_modo_libre_param #(
    .ANCHO_TECLA(8), .TECLA_BASE(65), .NUM_NOTAS(8), .ANCHO_NOTA(3),
    .CICLOS_NOTA(4), .CICLOS_PAUSA(0), .PROF_COLA(4)
  ) u_dut0 (
    .clk    (clk),
    .reset  (rst0),
    .io_bus (bus0)
  );

  fsm_modo_libre_param #(
    .ANCHO_TECLA(8), .TECLA_BASE(65), .NUM_NOTAS(8), .ANCHO_NOTA(3),
    .CICLOS_NOTA(4), .CICLOS_PAUSA(2), .PROF_COLA(4)
  ) u_dut2 (
    .clk    (clk),
    .reset  (rst2),
    .io_bus (bus2)
  );

  typedef struct {
    logic       rst;
    logic       ini;
    logic       det;
    logic [7:0] ent;
    logic       contar;
    logic [2:0] nota;
    logic       ocup;
    logic       desb;
    logic [2:0] nivel;
  } vec_t;

  vec_t tab[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input int rst, input int ini, input int det, input int ent,
                              input int contar, input int nota, input int ocup,
                              input int desb, input int nivel);
    vec_t v;
    v.rst    = 1'(rst);
    v.ini    = 1'(ini);
    v.det    = 1'(det);
    v.ent    = 8'(ent);
    v.contar = 1'(contar);
    v.nota   = 3'(nota);
    v.ocup   = 1'(ocup);
    v.desb   = 1'(desb);
    v.nivel  = 3'(nivel);
    return v;
  endfunction

  task automatic chk(input string nom, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0d expected %0d", nom, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [13:0] pat_c;
  logic [13:0] pat_o;

  initial begin
    rst0 = 1'b1;
    rst2 = 1'b1;
    bus0.inicio = 1'b0; bus0.detener = 1'b0; bus0.entrada = 8'd0;
    bus2.inicio = 1'b0; bus2.detener = 1'b0; bus2.entrada = 8'd0;

    // rst ini det ent | contar nota ocup desb nivel
    // keys before inicio and out-of-range keys
    tab.push_back(mk(0,0,0,65, 0,0,0,0,0));
    tab.push_back(mk(0,0,0, 0, 0,0,0,0,0));
    tab.push_back(mk(0,1,0, 0, 0,0,0,0,0));
    tab.push_back(mk(0,0,0,64, 0,0,0,0,0));
    tab.push_back(mk(0,0,0,73, 0,0,0,0,0));
    tab.push_back(mk(0,0,0, 0, 0,0,0,0,0));
    // single held key: one push, four sounding cycles
    tab.push_back(mk(0,0,0,65, 0,0,0,0,1));
    for (int i = 0; i < 4; i++) tab.push_back(mk(0,0,0,65, 1,0,1,0,0));
    for (int i = 0; i < 5; i++) tab.push_back(mk(0,0,0,65, 0,0,0,0,0));
    tab.push_back(mk(0,0,0, 0, 0,0,0,0,0));
    // four keys back to back
    tab.push_back(mk(0,0,0,65, 0,0,0,0,1));
    tab.push_back(mk(0,0,0,66, 1,0,1,0,1));
    tab.push_back(mk(0,0,0,67, 1,0,1,0,2));
    tab.push_back(mk(0,0,0,68, 1,0,1,0,3));
    tab.push_back(mk(0,0,0, 0, 1,0,1,0,3));
    for (int i = 0; i < 4; i++) tab.push_back(mk(0,0,0,0, 1,1,1,0,2));
    for (int i = 0; i < 4; i++) tab.push_back(mk(0,0,0,0, 1,2,1,0,1));
    for (int i = 0; i < 4; i++) tab.push_back(mk(0,0,0,0, 1,3,1,0,0));
    tab.push_back(mk(0,0,0, 0, 0,3,0,0,0));
    // queue fill and overflow
    tab.push_back(mk(0,0,0,65, 0,3,0,0,1));
    tab.push_back(mk(0,0,0,66, 1,0,1,0,1));
    tab.push_back(mk(0,0,0,67, 1,0,1,0,2));
    tab.push_back(mk(0,0,0,68, 1,0,1,0,3));
    tab.push_back(mk(0,0,0,69, 1,0,1,0,4));
    tab.push_back(mk(0,0,0,70, 1,1,1,0,4));
    tab.push_back(mk(0,0,0,71, 1,1,1,1,4));
    tab.push_back(mk(0,0,0,72, 1,1,1,1,4));
    tab.push_back(mk(0,0,0, 0, 1,1,1,0,4));
    for (int i = 0; i < 4; i++) tab.push_back(mk(0,0,0,0, 1,2,1,0,3));
    tab.push_back(mk(0,0,0, 0, 1,3,1,0,2));
    // stop mid-note with two queued, then reset mid-note
    tab.push_back(mk(0,0,1,65, 0,0,0,0,0));
    tab.push_back(mk(0,0,0,66, 0,0,0,0,0));
    tab.push_back(mk(0,0,0, 0, 0,0,0,0,0));
    tab.push_back(mk(0,1,0, 0, 0,0,0,0,0));
    tab.push_back(mk(0,0,0,67, 0,0,0,0,1));
    tab.push_back(mk(0,0,0,68, 1,2,1,0,1));
    tab.push_back(mk(1,0,0, 0, 0,0,0,0,0));
    tab.push_back(mk(0,0,0,65, 0,0,0,0,0));
    tab.push_back(mk(0,0,0, 0, 0,0,0,0,0));

    repeat (2) tick();
    chk("rst0_contar", 0, 32'(bus0.contar),     0);
    chk("rst0_nota",   0, 32'(bus0.notaSalida), 0);
    chk("rst0_ocup",   0, 32'(bus0.ocupado),    0);
    chk("rst0_desb",   0, 32'(bus0.desborde),   0);
    chk("rst0_nivel",  0, 32'(bus0.nivel),      0);
    chk("rst2_contar", 0, 32'(bus2.contar),     0);
    chk("rst2_nivel",  0, 32'(bus2.nivel),      0);

    for (int i = 0; i < tab.size(); i++) begin
      rst0         = tab[i].rst;
      bus0.inicio  = tab[i].ini;
      bus0.detener = tab[i].det;
      bus0.entrada = tab[i].ent;
      tick();
      chk("contar", i, 32'(bus0.contar),     32'(tab[i].contar));
      chk("nota",   i, 32'(bus0.notaSalida), 32'(tab[i].nota));
      chk("ocupado",i, 32'(bus0.ocupado),    32'(tab[i].ocup));
      chk("desborde",i,32'(bus0.desborde),   32'(tab[i].desb));
      chk("nivel",  i, 32'(bus0.nivel),      32'(tab[i].nivel));
    end
    rst0 = 1'b0; bus0.inicio = 1'b0; bus0.detener = 1'b0; bus0.entrada = 8'd0;

    // gap build: note, two silent cycles, next note
    rst2 = 1'b0;
    bus2.inicio = 1'b1;
    tick();
    bus2.inicio = 1'b0;
    bus2.entrada = 8'd65;
    tick();
    chk("gap_nivel_push", 0, 32'(bus2.nivel), 1);
    bus2.entrada = 8'd66;
    tick();
    pat_c = '0;
    pat_o = '0;
    for (int k = 0; k < 14; k++) begin
      pat_c = {pat_c[12:0], bus2.contar};
      pat_o = {pat_o[12:0], bus2.ocupado};
      if (k == 0) begin
        chk("gap_nota_first", k, 32'(bus2.notaSalida), 0);
        chk("gap_nivel_first", k, 32'(bus2.nivel), 1);
      end
      if (k == 4) chk("gap_nota_hold", k, 32'(bus2.notaSalida), 0);
      if (k == 6) begin
        chk("gap_nota_second", k, 32'(bus2.notaSalida), 1);
        chk("gap_nivel_second", k, 32'(bus2.nivel), 0);
      end
      if (k == 12) chk("gap_nota_idle", k, 32'(bus2.notaSalida), 1);
      bus2.entrada = 8'd0;
      tick();
    end
    chk("gap_contar_pattern", 0, 32'(pat_c), 32'(14'b11110011110000));
    chk("gap_ocupado_pattern", 0, 32'(pat_o), 32'(14'b11111111111100));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
